sdram_responder: RTL and testbench

- Avalon-MM-style slave that answers the active-low SDRAM command interface: addres/byte_en_n/data/read_n/write_n in, wait_rq out.
- Backed by a byte-enabled on-chip word RAM.
- Emulates SDRAM wait states and periodic refresh stalls.
- Serves as the on-chip and simulation stand-in for the external SDRAM controller, so traffic generators and the stream writers/readers can be exercised and counted without the board memory.

---
 rtl/sdram_pkg.sv | 8 +
 rtl/sdram_resp_ram.sv | 35 +++
 rtl/sdram_responder.sv | 152 +++++++++++++++
 tb/tb_sdram_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: interface widths and FSM encoding shared by the SDRAM responder files
package sdram_pkg;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W = 2;
  localparam int LANE_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT, REFRESH} state_t;
endpackage

// File: rtl/sdram_resp_ram.sv
// sdram_resp_ram: single-port byte-enabled write-first RAM with one-cycle registered read
module sdram_resp_ram
  import sdram_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   we,
  input  logic [DW/LANE_W-1:0]   be,
  input  logic [AW-1:0]          addr,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] merged;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < DW/LANE_W; i++)
      if (we && be[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    rdata_d = en ? merged : rdata_q;
  end
  // contents survive reset; only the output register is cleared
  always_ff @(posedge clk)
    for (int i = 0; i < DW/LANE_W; i++)
      if (en && we && be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
  always_ff @(posedge clk)
    if (!reset_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: active-low SDRAM command slave backed by on-chip RAM,
// emulating per-command wait states and periodic refresh stalls.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ADDR_W         = sdram_pkg::ADDR_W,
  parameter int DATA_W         = sdram_pkg::DATA_W,
  parameter int MEM_AW         = 10,
  parameter int WAIT_CYC       = 1,
  parameter int RD_LAT         = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_LEN    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          addres,
  input  logic [DATA_W/LANE_W-1:0]   byte_en_n,
  input  logic [DATA_W-1:0]          data,
  input  logic                       read_n,
  input  logic                       write_n,
  output logic                       wait_rq,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdata_valid,
  output logic [15:0]                wr_count,
  output logic [15:0]                rd_count,
  output logic                       err_cmd
);
  localparam int RFW = REFRESH_PERIOD > 1 ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RCW = REFRESH_LEN > 1 ? $clog2(REFRESH_LEN) : 1;
  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [RFW-1:0] rfc_q, rfc_d;
  logic pend_q, pend_d, err_q, err_d;
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic cmd, both, wait_c, acc, drop, clr, wrap, wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;
  logic unused_addr;
  assign unused_addr = ^addres[ADDR_W-1:MEM_AW];
  always_comb begin
    cmd = read_n ^ write_n;
    both = ~read_n & ~write_n;
    state_d = state_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    wait_c = 1'b0;
    acc = 1'b0;
    drop = 1'b0;
    clr = 1'b0;
    case (state_q)
      IDLE:
        if (pend_q) begin
          state_d = REFRESH;
          wait_c = 1'b1;
          rcnt_d = RCW'(REFRESH_LEN - 1);
        end else if (cmd && WAIT_CYC == 0) begin
          acc = 1'b1;
        end else if (cmd) begin
          state_d = WAIT;
          wait_c = 1'b1;
          wcnt_d = 4'(WAIT_CYC - 1);
        end
      WAIT:
        if (!cmd) begin
          drop = 1'b1;
          state_d = IDLE;
        end else begin
          wait_c = wcnt_q != 4'd0;
          wcnt_d = wcnt_q - 4'd1;
          acc = wcnt_q == 4'd0;
          state_d = wcnt_q == 4'd0 ? IDLE : WAIT;
        end
      REFRESH: begin
        wait_c = 1'b1;
        rcnt_d = rcnt_q - RCW'(1);
        clr = rcnt_q == '0;
        state_d = rcnt_q == '0 ? IDLE : REFRESH;
      end
      default: state_d = IDLE;
    endcase
    wrap = REFRESH_PERIOD != 0 && rfc_q == RFW'(REFRESH_PERIOD - 1);
    rfc_d = (REFRESH_PERIOD == 0 || wrap) ? '0 : rfc_q + RFW'(1);
    // a wrap while a request is still pending simply merges into it
    pend_d = (pend_q & ~clr) | wrap;
    wr_acc = acc & reset_n & ~write_n;
    rd_acc = acc & reset_n & ~read_n;
    err_d = err_q | both | drop;
    wr_cnt_d = wr_cnt_q + 16'(wr_acc);
    rd_cnt_d = rd_cnt_q + 16'(rd_acc);
    vld_d = '0;
    vld_d[0] = rd_acc;
    for (int k = 1; k < RD_LAT; k++) vld_d[k] = vld_q[k-1];
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      rcnt_q <= '0;
      rfc_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      rfc_q <= rfc_d;
      pend_q <= pend_d;
      err_q <= err_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      vld_q <= vld_d;
    end
  sdram_resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .en(wr_acc | rd_acc),
    .we(wr_acc),
    .be(~byte_en_n),
    .addr(addres[MEM_AW-1:0]),
    .wdata(data),
    .rdata(ram_rdata)
  );
  // RAM output already counts as the first latency stage
  if (RD_LAT == 1) begin : g_lat1
    logic [DATA_W-1:0] hold_q;
    always_ff @(posedge clk)
      if (!reset_n) hold_q <= '0;
      else hold_q <= readdata;
    assign readdata = vld_q[0] ? ram_rdata : hold_q;
  end else begin : g_latn
    logic [DATA_W-1:0] dat_q [RD_LAT-1];
    logic [DATA_W-1:0] dat_d [RD_LAT-1];
    always_comb begin
      dat_d = dat_q;
      if (vld_q[0]) dat_d[0] = ram_rdata;
      for (int k = 1; k < RD_LAT - 1; k++) if (vld_q[k]) dat_d[k] = dat_q[k-1];
    end
    always_ff @(posedge clk)
      if (!reset_n) dat_q <= '{default: '0};
      else dat_q <= dat_d;
    assign readdata = dat_q[RD_LAT-2];
  end
  assign wait_rq = ~reset_n | wait_c;
  assign readdata_valid = vld_q[RD_LAT-1];
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
  assign err_cmd = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: three responder instances (wait states, zero-wait, refresh) driven by a holding master
module tb_sdram_responder;
  localparam int N = 3;
  localparam int REF_LEN = 4;
  typedef struct {
    int d;
    logic [15:0] v;
    int c;
  } exp_t;
  typedef struct {
    bit wr;
    logic [24:0] a;
    logic [1:0] be;
    logic [15:0] wd;
    logic [15:0] ev;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n;
  logic [24:0] addres [N];
  logic [1:0] byte_en_n [N];
  logic [15:0] data [N];
  logic read_n [N];
  logic write_n [N];
  logic wait_rq [N];
  logic [15:0] readdata [N];
  logic readdata_valid [N];
  logic [15:0] wr_count [N];
  logic [15:0] rd_count [N];
  logic err_cmd [N];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int run1 = 0;
  int max_run = 0;
  exp_t sb [$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sdram_responder #(
      .WAIT_CYC(g == 1 ? 0 : 1),
      .RD_LAT(2),
      .REFRESH_PERIOD(g == 2 ? 64 : 0),
      .REFRESH_LEN(REF_LEN)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .addres(addres[g]),
      .byte_en_n(byte_en_n[g]),
      .data(data[g]),
      .read_n(read_n[g]),
      .write_n(write_n[g]),
      .wait_rq(wait_rq[g]),
      .readdata(readdata[g]),
      .readdata_valid(readdata_valid[g]),
      .wr_count(wr_count[g]),
      .rd_count(rd_count[g]),
      .err_cmd(err_cmd[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Master holds the command through wait_rq; returns at posedge+1 after the accepting edge.
  task automatic do_cmd(input int d, input bit wr, input logic [24:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input bit push, input logic [15:0] ev, output int waits);
    addres[d] = a;
    byte_en_n[d] = be;
    data[d] = wd;
    read_n[d] = wr;
    write_n[d] = !wr;
    waits = 0;
    @(negedge clk);
    while (wait_rq[d] && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 64) chk("cmd_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    if (!wr && push) sb.push_back('{d, ev, cyc + 1});
    read_n[d] = 1'b1;
    write_n[d] = 1'b1;
  endtask

  always @(negedge clk) begin
    run1 <= readdata_valid[1] ? run1 + 1 : 0;
    if (readdata_valid[1] && run1 + 1 > max_run) max_run <= run1 + 1;
    for (int d = 0; d < N; d++)
      if (readdata_valid[d]) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: dut%0d strobed with 0x%0h, required no strobe", d, readdata[d]);
        end else begin
          e_mon = sb.pop_front();
          chk("rd_dut", 32'(d), 32'(e_mon.d));
          chk("rd_data", 32'(readdata[d]), 32'(e_mon.v));
          chk("rd_latency_cycle", 32'(cyc), 32'(e_mon.c));
        end
      end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int w, nw, nr, bad, nref;
    vec_t tv [15];
    tv[0]  = '{1'b1, 25'h5,       2'b00, 16'h1234, 16'h0};
    tv[1]  = '{1'b0, 25'h5,       2'b00, 16'h0,    16'h1234};
    tv[2]  = '{1'b1, 25'h7,       2'b00, 16'hAAAA, 16'h0};
    tv[3]  = '{1'b1, 25'h7,       2'b10, 16'h5511, 16'h0};
    tv[4]  = '{1'b0, 25'h7,       2'b11, 16'h0,    16'hAA11};
    tv[5]  = '{1'b1, 25'h7,       2'b11, 16'hFFFF, 16'h0};
    tv[6]  = '{1'b0, 25'h7,       2'b00, 16'h0,    16'hAA11};
    tv[7]  = '{1'b1, 25'h400,     2'b00, 16'hBEEF, 16'h0};
    tv[8]  = '{1'b0, 25'h0,       2'b00, 16'h0,    16'hBEEF};
    tv[9]  = '{1'b1, 25'h9,       2'b00, 16'h1111, 16'h0};
    tv[10] = '{1'b1, 25'h9,       2'b01, 16'h22FF, 16'h0};
    tv[11] = '{1'b0, 25'h9,       2'b00, 16'h0,    16'h2211};
    tv[12] = '{1'b0, 25'h1FFFC05, 2'b00, 16'h0,    16'h1234};
    tv[13] = '{1'b1, 25'hC,       2'b00, 16'hABCD, 16'h0};
    tv[14] = '{1'b0, 25'hC,       2'b00, 16'h0,    16'hABCD};
    reset_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      read_n[d] = 1'b1;
      write_n[d] = 1'b1;
      addres[d] = '0;
      byte_en_n[d] = 2'b11;
      data[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) chk("rst_wait_rq", 32'(wait_rq[d]), 32'd1);
    chk("rst_valid", 32'(readdata_valid[0]), 32'd0);
    chk("rst_readdata", 32'(readdata[0]), 32'd0);
    chk("rst_wr_count", 32'(wr_count[0]), 32'd0);
    chk("rst_rd_count", 32'(rd_count[0]), 32'd0);
    chk("rst_err", 32'(err_cmd[0]), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // command abandoned during its wait state
    do_cmd(2, 1'b1, 25'd3, 2'b00, 16'h1111, 1'b0, 16'h0, w);
    chk("d2_waits", 32'(w), 32'd1);
    addres[2] = 25'd3;
    data[2] = 16'h7777;
    byte_en_n[2] = 2'b00;
    write_n[2] = 1'b0;
    @(negedge clk);
    chk("drop_stall", 32'(wait_rq[2]), 32'd1);
    @(posedge clk);
    #1 write_n[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_err", 32'(err_cmd[2]), 32'd1);
    chk("drop_wr_count", 32'(wr_count[2]), 32'd1);
    do_cmd(2, 1'b0, 25'd3, 2'b00, 16'h0, 1'b1, 16'h1111, w);

    nw = 0;
    nr = 0;
    for (int i = 0; i < 15; i++) begin
      do_cmd(0, tv[i].wr, tv[i].a, tv[i].be, tv[i].wd, 1'b1, tv[i].ev, w);
      chk("vec_waits", 32'(w), 32'd1);
      if (tv[i].wr) nw++;
      else nr++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("tbl_wr_count", 32'(wr_count[0]), 32'(nw));
    chk("tbl_rd_count", 32'(rd_count[0]), 32'(nr));
    chk("tbl_drained", 32'(sb.size()), 32'd0);
    chk("hold_readdata", 32'(readdata[0]), 32'hABCD);
    chk("hold_valid", 32'(readdata_valid[0]), 32'd0);

    // both commands low for one cycle
    addres[0] = 25'd5;
    data[0] = 16'hFFFF;
    byte_en_n[0] = 2'b00;
    read_n[0] = 1'b0;
    write_n[0] = 1'b0;
    @(posedge clk);
    #1;
    read_n[0] = 1'b1;
    write_n[0] = 1'b1;
    @(negedge clk);
    chk("both_err", 32'(err_cmd[0]), 32'd1);
    chk("both_wr_count", 32'(wr_count[0]), 32'(nw));
    chk("both_rd_count", 32'(rd_count[0]), 32'(nr));
    @(posedge clk);
    #1;
    do_cmd(0, 1'b0, 25'd5, 2'b00, 16'h0, 1'b1, 16'h1234, w);
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err_cmd[0]), 32'd1);

    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_cmd(1, 1'b1, 25'(i), 2'b00, 16'hC000 | 16'(i), 1'b0, 16'h0, w);
      bad += w;
    end
    for (int i = 0; i < 16; i++) begin
      do_cmd(1, 1'b0, 25'(i), 2'b00, 16'h0, 1'b1, 16'hC000 | 16'(i), w);
      bad += w;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_waits", 32'(bad), 32'd0);
    chk("b2b_run", 32'(max_run), 32'd16);
    chk("b2b_rd_count", 32'(rd_count[1]), 32'd16);
    chk("b2b_wr_count", 32'(wr_count[1]), 32'd16);

    // refresh stalls: idle-cycle entry plus REF_LEN refresh cycles on top of the normal wait
    bad = 0;
    nref = 0;
    for (int i = 0; i < 60; i++) begin
      do_cmd(2, 1'b1, 25'(100 + i), 2'b00, 16'(i), 1'b0, 16'h0, w);
      if (w == REF_LEN + 2) nref++;
      else if (w != 1) bad++;
    end
    chk("ref_bad_stall", 32'(bad), 32'd0);
    chk("ref_seen", 32'(nref >= 1 && nref <= 3), 32'd1);
    chk("ref_wr_count", 32'(wr_count[2]), 32'd61);

    do_cmd(0, 1'b0, 25'd5, 2'b00, 16'h0, 1'b0, 16'h0, w);
    reset_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) chk("mid_rst_wait_rq", 32'(wait_rq[d]), 32'd1);
    chk("mid_rst_valid", 32'(readdata_valid[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid2", 32'(readdata_valid[0]), 32'd0);
    chk("mid_rst_wr_count", 32'(wr_count[0]), 32'd0);
    chk("mid_rst_rd_count", 32'(rd_count[0]), 32'd0);
    chk("mid_rst_err", 32'(err_cmd[0]), 32'd0);
    chk("mid_rst_readdata", 32'(readdata[0]), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_cmd(0, 1'b0, 25'd5, 2'b00, 16'h0, 1'b1, 16'h1234, w);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_rd_count", 32'(rd_count[0]), 32'd1);
    chk("post_rst_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
